descriptor_tx: RTL
==================

Name: descriptor_tx

Overview:
Output end of the feature pipeline, and the transmit counterpart to the camera image input. It accepts descriptor records (keypoint_value plus channel1..4) from the descriptor stage and buffers them in a small record FIFO. Each record is sent to the host as a framed, checksummed 8N1 UART byte stream on a single tx line. It also reports per-image completion once descriptor_done has been seen and every buffered record has left the wire.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)
FIFO_DEPTH, 4, record FIFO depth, power of two (>=2)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
descriptor_valid  input  1  one-cycle strobe; record inputs valid this cycle
keypoint_value  input  32  keypoint coordinates/word
channel1  input  16  descriptor channel 1
channel2  input  16  descriptor channel 2
channel3  input  16  descriptor channel 3
channel4  input  16  descriptor channel 4
descriptor_done  input  1  one-cycle strobe; no more records for this image
tx  output  1  UART serial out, idle high
busy  output  1  FIFO non-empty or serializer not IDLE
overflow  output  1  sticky; a record was dropped because the FIFO was full
tx_done  output  1  one-cycle pulse; image fully transmitted

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, overflow=0, tx_done=0; FIFO emptied; done latch cleared; FSM=IDLE. Reset mid-frame aborts the frame immediately; tx goes high without waiting for a clock edge.
- Record = 96 bits. Payload byte order: keypoint_value[31:24], [23:16], [15:8], [7:0], then channel1[15:8], channel1[7:0], through channel4[7:0]. This gives 12 payload bytes.
- Frame = SYNC_BYTE, 12 payload bytes, CHK. CHK = XOR of the 12 payload bytes. 14 bytes total.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. No idle gap between bytes within a frame.
- FIFO push on a clk edge with descriptor_valid=1:
  - If not full, the record is written.
  - If full, the record is dropped and overflow is set. overflow clears only on reset.
  - A pop on the same edge frees a slot, so a push to a full FIFO with a simultaneous pop is accepted.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into the frame register, set byte index=0, go to LOAD.
  - LOAD: select byte[index] into the shift register; go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: shift out 8 bits.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then if index<13: index+1, go to LOAD. Else go to IDLE.
- Frame timing: the LOAD cycle costs one extra cycle per byte, during which tx=1. A frame therefore occupies 14*(10*CLKS_PER_BIT+1) cycles plus one IDLE cycle.
- Latency: record pushed at edge t into an empty FIFO with the FSM idle. Pop occurs at edge t+1, LOAD at t+2, and tx falls at edge t+2.
- Done handling: descriptor_done sets the done latch, and may coincide with the last descriptor_valid. tx_done pulses for one cycle on the first edge where latch=1, FIFO empty and FSM=IDLE. The latch clears on that same edge. A descriptor_done arriving with nothing pending pulses tx_done on the next edge.
- busy is combinational: (count!=0) | (state!=IDLE).
- Counter widths: bit counter covers 0..CLKS_PER_BIT-1; byte index is 4 bits; FIFO count covers 0..FIFO_DEPTH. All pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Single record (CLKS_PER_BIT=4): keypoint_value=32'h0012_0034, channel1..4=16'h0102, 16'h0304, 16'h0506, 16'h0708.
  - Decoded bytes: A5 00 12 00 34 01 02 03 04 05 06 07 08 2E.
  - tx falls 2 edges after the push; frame lasts 574 cycles; busy falls after the final stop bit.
- Bit timing: after a single push, measure start-bit width and bit order. Each bit is 4 cycles; SYNC appears on tx as 0,1,0,1,0,0,1,0,1 followed by stop 1.
- Overflow (FIFO_DEPTH=4): 6 consecutive descriptor_valid cycles with distinct records.
  - Records 1–5 are transmitted in order; record 6 is dropped.
  - overflow=1 from the 6th push edge onward, and stays set after all 5 frames complete.
- Completion: 2 records, then descriptor_done asserted together with the 2nd descriptor_valid. tx_done pulses exactly once, on the edge after the 2nd frame's final stop bit completes. No pulse occurs earlier.
- Reset mid-frame: assert rst_n=0 during the DATA bits of payload byte 5 with 2 records queued.
  - tx=1 and busy=0 immediately.
  - After release, no further bytes are emitted until a new push; the new record is sent as a complete frame.
- Empty done: descriptor_done with an empty FIFO and the FSM idle gives a tx_done pulse on the next edge; tx stays high.

Source files
------------

// File: rtl/descriptor_tx_if.sv
// Signal bundle between the descriptor stage and the descriptor UART transmitter:
// record inputs, end-of-image strobe, serial line and status outputs.
interface descriptor_tx_if;
   logic        descriptor_valid;
   logic [31:0] keypoint_value;
   logic [15:0] channel1;
   logic [15:0] channel2;
   logic [15:0] channel3;
   logic [15:0] channel4;
   logic        descriptor_done;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic        tx_done;

   modport master (
      output descriptor_valid, keypoint_value, channel1, channel2, channel3, channel4,
             descriptor_done,
      input  tx, busy, overflow, tx_done
   );

   modport slave (
      input  descriptor_valid, keypoint_value, channel1, channel2, channel3, channel4,
             descriptor_done,
      output tx, busy, overflow, tx_done
   );
endinterface

// File: rtl/descriptor_tx.sv
// Buffers descriptor records in a small FIFO and sends each one as a framed,
// XOR-checksummed 8N1 UART byte stream; flags image completion once drained.
module descriptor_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input logic            clk,
   input logic            rst_n,
   descriptor_tx_if.slave bus
);
   // state   | meaning
   // S_IDLE  | waiting for a record; pops FIFO head into the frame register
   // S_LOAD  | copies byte[idx] of the frame into the shift register, tx high
   // S_START | start bit, tx low for CLKS_PER_BIT cycles
   // S_DATA  | eight data bits, LSB first
   // S_STOP  | stop bit, tx high; then next byte or back to idle

   localparam int unsigned BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  COUNT_MAX = CW'(FIFO_DEPTH);
   localparam logic [3:0]     LAST_BYTE = 4'd13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t         state_q, state_d;
   logic [95:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           ovf_q, done_q, tx_done_q;
   logic [95:0]    frame_q;
   logic [3:0]     idx_q;
   logic [7:0]     sh_q;
   logic [BCW-1:0] bcnt_q;
   logic [2:0]     bitn_q;

   logic [95:0]    rec_in;
   logic [7:0]     byte_sel, chk;
   logic           push_ok, pop, bit_tc, fire, tx_o, busy_o;

   assign rec_in  = {bus.keypoint_value, bus.channel1, bus.channel2, bus.channel3, bus.channel4};
   assign bit_tc  = (bcnt_q == '0);
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign push_ok = bus.descriptor_valid && ((count_q != COUNT_MAX) || pop);
   assign fire    = done_q && (count_q == '0) && (state_q == S_IDLE);

   always_comb begin
      chk = '0;
      for (int k = 0; k < 12; k++) chk = chk ^ frame_q[8*k +: 8];
   end

   always_comb begin
      byte_sel = chk;
      if (idx_q == 4'd0) begin
         byte_sel = SYNC_BYTE;
      end else begin
         for (int k = 1; k <= 12; k++)
            if (idx_q == 4'(k)) byte_sel = frame_q[8*(12-k) +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (count_q != '0) state_d = S_LOAD;
         S_LOAD:  state_d = S_START;
         S_START: if (bit_tc) state_d = S_DATA;
         S_DATA:  if (bit_tc && (bitn_q == 3'd7)) state_d = S_STOP;
         S_STOP:  if (bit_tc) state_d = (idx_q != LAST_BYTE) ? S_LOAD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop    = (state_q == S_IDLE) && (count_q != '0);
      busy_o = (count_q != '0) || (state_q != S_IDLE);
      case (state_q)
         S_START: tx_o = 1'b0;
         S_DATA:  tx_o = sh_q[0];
         default: tx_o = 1'b1;
      endcase
   end

   assign bus.tx       = tx_o;
   assign bus.busy     = busy_o;
   assign bus.overflow = ovf_q;
   assign bus.tx_done  = tx_done_q;

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rec_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_ok && !pop)      count_q <= count_q + CW'(1);
         else if (!push_ok && pop) count_q <= count_q - CW'(1);
         if (bus.descriptor_valid && !push_ok) ovf_q <= 1'b1;
         done_q    <= bus.descriptor_done | (done_q & ~fire);
         tx_done_q <= fire;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         bcnt_q  <= '0;
         bitn_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  frame_q <= mem_q[rd_ptr_q];
                  idx_q   <= '0;
               end
            end
            S_LOAD: begin
               sh_q   <= byte_sel;
               bcnt_q <= BIT_LAST;
            end
            S_START: begin
               if (bit_tc) begin
                  bcnt_q <= BIT_LAST;
                  bitn_q <= '0;
               end else begin
                  bcnt_q <= bcnt_q - BCW'(1);
               end
            end
            S_DATA: begin
               if (bit_tc) begin
                  bcnt_q <= BIT_LAST;
                  if (bitn_q != 3'd7) begin
                     sh_q   <= sh_q >> 1;
                     bitn_q <= bitn_q + 3'd1;
                  end
               end else begin
                  bcnt_q <= bcnt_q - BCW'(1);
               end
            end
            S_STOP: begin
               if (bit_tc) begin
                  if (idx_q != LAST_BYTE) idx_q <= idx_q + 4'd1;
               end else begin
                  bcnt_q <= bcnt_q - BCW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
